// File: rtl/noc_pkg.sv
// Shared constants and types for the 5-port wormhole NoC router.
package noc_pkg;

  localparam int NP     = 5;
  localparam int PW     = $clog2(NP);
  localparam int FLIT_W = 64;

  typedef enum logic [PW-1:0] {
    PORT_N,
    PORT_E,
    PORT_S,
    PORT_W,
    PORT_L
  } port_e;

  typedef enum logic {
    IDLE,
    LOCKED
  } alloc_state_e;

  // Port index arithmetic modulo NP, used for round-robin search and pointer advance.
  function automatic logic [PW-1:0] port_add(input logic [PW-1:0] p, input int unsigned k);
    return PW'((32'(p) + k) % NP);
  endfunction

endpackage

// File: rtl/noc_sw_alloc_if.sv
// Request/grant and output-side signals between the input buffers, the allocator and the crossbar.
interface noc_sw_alloc_if;
  import noc_pkg::*;

  logic [NP-1:0]    req_valid;
  logic [NP*PW-1:0] req_port;
  logic [NP-1:0]    req_tail;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    credit_in;
  logic [NP-1:0]    out_valid;
  logic [NP*PW-1:0] out_sel;
  logic             err_credit_ovf;
  logic             err_bad_port;

  modport master (
    output req_valid, req_port, req_tail, credit_in,
    input  gnt, out_valid, out_sel, err_credit_ovf, err_bad_port
  );

  modport slave (
    input  req_valid, req_port, req_tail, credit_in,
    output gnt, out_valid, out_sel, err_credit_ovf, err_bad_port
  );

endinterface

// File: rtl/noc_rr_arb.sv
// Round-robin arbiter: first requester at or above ptr, wrapping modulo NP.
module noc_rr_arb
  import noc_pkg::*;
(
  input  logic [NP-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NP-1:0] gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NP; k++) begin
      cand = port_add(ptr, k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/noc_sw_alloc.sv
// Switch allocator: per-output wormhole lock with round-robin allocation and
// downstream credit gating. Drives crossbar selects and input dequeue grants.
module noc_sw_alloc
  import noc_pkg::*;
#(
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input logic          clk,
  input logic          rst,
  noc_sw_alloc_if.slave bus
);

  logic [PW-1:0] port_of [NP];
  logic [NP-1:0] bad_req;
  logic [NP-1:0] cand [NP];

  logic [NP-1:0] arb_gnt [NP];
  logic [PW-1:0] arb_idx [NP];
  logic [NP-1:0] arb_any;

  alloc_state_e  state_q  [NP], state_d  [NP];
  logic [PW-1:0] owner_q  [NP], owner_d  [NP];
  logic [PW-1:0] rr_q     [NP], rr_d     [NP];
  logic [CW-1:0] credit_q [NP], credit_d [NP];
  logic [NP-1:0] fire;
  logic          err_ovf_q, err_ovf_d;
  logic          err_bad_q, err_bad_d;
  logic [NP-1:0] hits [NP];

  // A request for a nonexistent port can never match any output index, so it never wins.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      port_of[i] = bus.req_port[i*PW +: PW];
      bad_req[i] = bus.req_valid[i] && (port_of[i] >= PW'(NP));
    end
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        cand[o][i] = bus.req_valid[i] && (port_of[i] == PW'(o));
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_arb
    noc_rr_arb u_arb (
      .req (cand[o]),
      .ptr (rr_q[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o]),
      .any (arb_any[o])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o]  <= IDLE;
        owner_q[o]  <= '0;
        rr_q[o]     <= '0;
        credit_q[o] <= CW'(CREDITS);
      end
      err_ovf_q <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_q[o]     <= rr_d[o];
        credit_q[o] <= credit_d[o];
      end
      err_ovf_q <= err_ovf_d;
      err_bad_q <= err_bad_d;
    end
  end

  // Allocation takes a full cycle; a locked output fires only when its owner
  // still points here and a downstream slot is free.
  always_comb begin
    bus.gnt       = '0;
    bus.out_valid = '0;
    bus.out_sel   = '0;
    fire          = '0;
    err_ovf_d     = err_ovf_q;
    err_bad_d     = err_bad_q | (|bad_req);
    for (int o = 0; o < NP; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_d[o]     = rr_q[o];
      credit_d[o] = credit_q[o];
      case (state_q[o])
        IDLE: begin
          if (arb_any[o]) begin
            state_d[o] = LOCKED;
            owner_d[o] = arb_idx[o];
          end
        end
        LOCKED: begin
          fire[o] = bus.req_valid[owner_q[o]] && (port_of[owner_q[o]] == PW'(o)) &&
                    (credit_q[o] != '0);
          bus.out_sel[o*PW +: PW] = owner_q[o];
          if (fire[o]) bus.gnt[owner_q[o]] = 1'b1;
          if (fire[o] && bus.req_tail[owner_q[o]]) begin
            state_d[o] = IDLE;
            rr_d[o]    = port_add(owner_q[o], 1);
          end
        end
      endcase
      bus.out_valid[o] = fire[o];
      if (fire[o] && !bus.credit_in[o]) begin
        credit_d[o] = credit_q[o] - 1'b1;
      end else if (!fire[o] && bus.credit_in[o]) begin
        if (credit_q[o] == CW'(CREDITS)) err_ovf_d = 1'b1;
        else credit_d[o] = credit_q[o] + 1'b1;
      end
    end
  end

  assign bus.err_credit_ovf = err_ovf_q;
  assign bus.err_bad_port   = err_bad_q;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      for (int o = 0; o < NP; o++) begin
        hits[i][o] = fire[o] && (owner_q[o] == PW'(i));
      end
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_chk
    a_gnt_per_input: assert property (@(posedge clk) disable iff (rst) $onehot0(hits[i]));
    a_arb_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(arb_gnt[i]) && (arb_any[i] == (|arb_gnt[i])));
  end

  a_gnt_matches_out: assert property (@(posedge clk) disable iff (rst)
    $countones(bus.gnt) == $countones(bus.out_valid));

endmodule

// File: tb/tb_noc_sw_alloc.sv
// Directed bench for noc_sw_alloc: a behavioural upstream feeds flit queues,
// and a negedge monitor matches every output fire against a scoreboard queue.
module tb_noc_sw_alloc;
  import noc_pkg::*;

  typedef struct {
    logic [PW-1:0] port;
    logic          tail;
  } flit_t;

  typedef struct {
    int cyc;
    int port;
    int sel;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            t0 = 0;
  logic [NP-1:0] gnt_seen = '0;
  flit_t         inq [NP][$];
  exp_t          sb [$];

  noc_sw_alloc_if bus ();

  noc_sw_alloc #(.CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle an output fires, it must be the next scoreboard entry, in the right cycle.
  always @(negedge clk) begin : mon
    int   sel;
    exp_t e;
    gnt_seen = bus.gnt;
    if (!rst) begin
      checks++;
      if ($countones(bus.gnt) != $countones(bus.out_valid)) begin
        errors++;
        $display("[TB] FAIL gnt_count cyc=%0d: actual gnt=%b out_valid=%b", cyc, bus.gnt, bus.out_valid);
      end
      for (int o = 0; o < NP; o++) begin
        if (bus.out_valid[o]) begin
          sel = int'(bus.out_sel[o*PW +: PW]);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_fire: actual out%0d sel=%0d at cyc=%0d required no fire", o, sel, cyc);
          end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.port != o || e.sel != sel) begin
              errors++;
              $display("[TB] FAIL fire_out%0d: actual cyc=%0d sel=%0d required cyc=%0d port=%0d sel=%0d",
                       o, cyc, sel, e.cyc, e.port, e.sel);
            end
          end
          checks++;
          if (sel >= NP || bus.gnt[sel] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gnt_owner_out%0d: actual gnt=%b required bit %0d set", o, bus.gnt, sel);
          end
        end
      end
    end
  end

  // One cycle of upstream behaviour: dequeue granted heads, then present the new heads.
  task automatic applyStimulus(input logic [NP-1:0] cr);
    logic [NP-1:0]    v;
    logic [NP-1:0]    t;
    logic [NP*PW-1:0] p;
    flit_t            f;
    @(posedge clk);
    #1;
    v = '0;
    t = '0;
    p = '0;
    for (int i = 0; i < NP; i++) begin
      if (gnt_seen[i] && inq[i].size() > 0) f = inq[i].pop_front();
      if (inq[i].size() > 0) begin
        v[i]          = 1'b1;
        t[i]          = inq[i][0].tail;
        p[i*PW +: PW] = inq[i][0].port;
      end
    end
    bus.req_valid = v;
    bus.req_tail  = t;
    bus.req_port  = p;
    bus.credit_in = cr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus('0);
  endtask

  task automatic push_flits(input int src, input int dst, input int n, input bit last_tail);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.port = PW'(dst);
      f.tail = last_tail && (k == n - 1);
      inq[src].push_back(f);
    end
  endtask

  task automatic expect_fire(input int dc, input int port, input int sel);
    exp_t e;
    e.cyc  = t0 + dc;
    e.port = port;
    e.sel  = sel;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checkOutput({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    checkOutput({name, "_out_sel"}, 32'(bus.out_sel), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_port  = '0;
    bus.req_tail  = '0;
    bus.credit_in = '0;

    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("rst_err_ovf", 32'(bus.err_credit_ovf), 32'd0);
    checkOutput("rst_err_bad", 32'(bus.err_bad_port), 32'd0);

    $display("[TB] single-flit input 0 -> output 2");
    push_flits(0, 2, 1, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    expect_fire(1, 2, 0);
    idle_cycles(3);
    applyStimulus(5'b00100);
    idle_cycles(1);
    check_drained("t1");

    $display("[TB] inputs 1,3,4 contend for output 0");
    push_flits(1, 0, 1, 1'b1);
    push_flits(3, 0, 1, 1'b1);
    push_flits(4, 0, 1, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    expect_fire(1, 0, 1);
    expect_fire(3, 0, 3);
    expect_fire(5, 0, 4);
    idle_cycles(6);
    repeat (3) applyStimulus(5'b00001);
    idle_cycles(1);
    check_drained("t2");

    $display("[TB] pointer positions on outputs 0 and 2");
    push_flits(2, 0, 1, 1'b1);
    push_flits(4, 0, 1, 1'b1);
    push_flits(0, 2, 1, 1'b1);
    push_flits(1, 2, 1, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    expect_fire(1, 0, 2);
    expect_fire(1, 2, 1);
    expect_fire(3, 0, 4);
    expect_fire(3, 2, 0);
    idle_cycles(4);
    repeat (2) applyStimulus(5'b00101);
    idle_cycles(1);
    check_drained("t2b");

    $display("[TB] 6-flit packet input 2 -> output 1, credit stall");
    push_flits(2, 1, 6, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    for (int k = 1; k <= 4; k++) expect_fire(k, 1, 2);
    expect_fire(9, 1, 2);
    expect_fire(10, 1, 2);
    idle_cycles(7);
    @(negedge clk);
    checkOutput("t3_stall_gnt", 32'(bus.gnt), 32'd0);
    applyStimulus(5'b00010);
    applyStimulus(5'b00010);
    idle_cycles(3);
    repeat (4) applyStimulus(5'b00010);
    idle_cycles(1);
    check_drained("t3");

    $display("[TB] simultaneous fire and credit on output 3, overflow");
    push_flits(0, 3, 4, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    for (int k = 1; k <= 4; k++) expect_fire(k, 3, 0);
    applyStimulus('0);
    applyStimulus('0);
    applyStimulus(5'b01000);
    applyStimulus('0);
    push_flits(3, 3, 3, 1'b1);
    applyStimulus('0);
    expect_fire(6, 3, 3);
    expect_fire(10, 3, 3);
    expect_fire(11, 3, 3);
    idle_cycles(3);
    applyStimulus(5'b01000);
    applyStimulus(5'b01000);
    applyStimulus('0);
    idle_cycles(1);
    checkOutput("t4_ovf_before", 32'(bus.err_credit_ovf), 32'd0);
    repeat (4) applyStimulus(5'b01000);
    applyStimulus(5'b01000);
    @(negedge clk);
    checkOutput("t4_ovf_not_yet", 32'(bus.err_credit_ovf), 32'd0);
    applyStimulus('0);
    @(negedge clk);
    checkOutput("t4_ovf_set", 32'(bus.err_credit_ovf), 32'd1);
    idle_cycles(3);
    checkOutput("t4_ovf_sticky", 32'(bus.err_credit_ovf), 32'd1);
    check_drained("t4");

    $display("[TB] bad port on input 4, input 0 -> output 4");
    push_flits(4, 6, 1, 1'b1);
    push_flits(0, 4, 1, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    expect_fire(1, 4, 0);
    @(negedge clk);
    checkOutput("t5_bad_not_yet", 32'(bus.err_bad_port), 32'd0);
    applyStimulus('0);
    @(negedge clk);
    checkOutput("t5_bad_set", 32'(bus.err_bad_port), 32'd1);
    idle_cycles(3);
    checkOutput("t5_no_gnt4", 32'(bus.gnt[4]), 32'd0);
    inq[4].delete();
    idle_cycles(2);
    checkOutput("t5_bad_sticky", 32'(bus.err_bad_port), 32'd1);
    applyStimulus(5'b10000);
    idle_cycles(1);
    check_drained("t5");

    $display("[TB] reset mid-packet on output 1");
    push_flits(2, 1, 3, 1'b0);
    applyStimulus('0);
    t0 = cyc;
    for (int k = 1; k <= 3; k++) expect_fire(k, 1, 2);
    idle_cycles(4);
    rst = 1'b1;
    for (int i = 0; i < NP; i++) inq[i].delete();
    applyStimulus('0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("t6_out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("t6_err_ovf", 32'(bus.err_credit_ovf), 32'd0);
    checkOutput("t6_err_bad", 32'(bus.err_bad_port), 32'd0);
    push_flits(3, 1, 4, 1'b1);
    applyStimulus('0);
    t0 = cyc;
    for (int k = 1; k <= 4; k++) expect_fire(k, 1, 3);
    idle_cycles(6);
    check_drained("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_sw_alloc.md
Name: noc_sw_alloc

Overview:
- Switch allocator and output-credit tracker for the 5-port 64-bit wormhole NoC router.
- Each output port gets its own round-robin arbiter over the input ports that request it. The winner is locked to that output until its tail flit crosses.
- Tracks downstream buffer credits per output and gates grants so no flit is sent without a credit.
- Drives the crossbar select and the per-input dequeue grant. The router datapath is pure muxing around this block.

Parameters:
- NP, 5, number of router ports (N/E/S/W/Local); port index width PW = $clog2(NP).
- CREDITS, 4, downstream input-buffer depth per output; reset value of every credit counter.
- CW, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  router clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NP  input i has a flit at its buffer head.
- req_port  in  NP*PW  requested output port of input i, packed by input index.
- req_tail  in  NP  head flit of input i is a tail (single-flit packet: head and tail both set).
- gnt  out  NP  input i's flit transfers this cycle; upstream dequeues.
- credit_in  in  NP  downstream of output o freed one buffer slot.
- out_valid  out  NP  output o drives a flit this cycle.
- out_sel  out  NP*PW  crossbar select for output o (winning input index).
- err_credit_ovf  out  1  sticky: credit_in arrived with the counter already at CREDITS.
- err_bad_port  out  1  sticky: req_valid with req_port >= NP.

Behaviour:
Per-output FSM, states IDLE and LOCKED(owner):
- IDLE:
  - Candidates are inputs i with req_valid[i] and req_port[i]==o.
  - Search starts at rr_ptr[o] and ascends mod NP; first candidate wins. The winner is registered as owner and the state moves to LOCKED next cycle.
  - No grant in the allocation cycle, so allocation latency is 1 cycle.
- LOCKED:
  - fire[o] = req_valid[owner] && req_port[owner]==o && credit[o]!=0.
  - Combinationally: gnt[owner]=fire[o]; out_valid[o]=fire[o]; out_sel[o]=owner.
- Tail release:
  - fire[o] && req_tail[owner] returns the output to IDLE next cycle, with rr_ptr[o] = (owner+1) mod NP.
  - Earliest re-allocation of output o is the cycle after release, so a packet costs one bubble per output.
- Non-tail behaviour:
  - Owner bubbles (req_valid low) keep the lock; no timeout.
  - If the owner's req_port changes while locked: no grant, lock held. This is a protocol violation, not flagged.

Credits:
- credit[o] resets to CREDITS.
- Next value: -1 on fire only; +1 on credit_in only; unchanged if both or neither.
- credit_in with credit==CREDITS and no fire: counter holds, err_credit_ovf sets.

Other rules:
- An input requests one output, so gnt is at most one-hot per input and per output. Both are asserted invariants.
- out_sel[o] outside LOCKED is 0.
- err_bad_port: sets on req_valid[i] && req_port[i]>=NP. The request never wins.
- Error flags: both sticky, cleared only by rst.

Reset, synchronous (rst high at posedge), applies even mid-packet:
- All outputs IDLE, rr_ptr=0, credits=CREDITS, error flags 0.
- gnt=0, out_valid=0, out_sel=0.
- Any in-flight packet is dropped; upstream must also reset.

Decomposition:
- Package noc_pkg holds:
  - NP, PW, flit width 64;
  - port enum PORT_N, PORT_E, PORT_S, PORT_W, PORT_L;
  - alloc_state_e {IDLE, LOCKED}.
- Sub-module noc_rr_arb (NP-wide request vector plus pointer in, one-hot grant plus index out) is instantiated once per output.
- Credit counters and lock state stay in noc_sw_alloc.

Test Plan:
- Single-flit packet, input 0 to output 2, credits full: cycle 1 allocate. Cycle 2 gnt[0]=1, out_sel[2]=0, credit[2] 4→3. Cycle 3 output 2 IDLE, rr_ptr[2]=1.
- Inputs 1, 3, 4 all request output 0 with single-flit packets, rr_ptr=0: grants in order 1, 3, 4. Each grant is followed by a 1-cycle allocation bubble. rr_ptr ends at 0.
- 6-flit packet from input 2 to output 1, no credit_in: 4 flits fire, then gnt[2]=0 with the lock held. Pulse credit_in[1] twice: remaining 2 fire, tail releases.
- Simultaneous fire and credit_in on output 3 at credit=2: credit stays 2. credit_in with credit=4 and no fire: err_credit_ovf=1 and stays 1.
- Input 4 with req_port=6: never granted, err_bad_port=1. Input 0 head-of-line to output 4 in the same cycle is unaffected.
- rst asserted mid-packet (output 1 locked, credit=1): next cycle all out_valid=0, credits=4, state IDLE. New request allocates normally after rst deasserts.
